// File: rtl/data_mem_responder_pkg.sv
// Shared types and sizing helpers for the data-memory responder.
// No logic; latency and backpressure are properties of the modules that import this.
package data_mem_responder_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

    localparam int unsigned WordBytes = 4;

    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Response shift pipeline: Depth cycles from push to head, one entry per stage.
// No backpressure; the head is presented for exactly one cycle.
module mem_rsp_pipe
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     in_vld_i,
    input  mem_rsp_t in_dat_i,
    output logic     out_vld_o,
    output mem_rsp_t out_dat_o
);

    logic [Depth-1:0] vld_q;
    logic [Depth-1:0] vld_d;
    mem_rsp_t         dat_q [Depth];

    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_vld_i;
        for (int i = 1; i < Depth; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Payload is not reset; the head is masked by its valid bit instead.
    always_ff @(posedge clk_i) begin
        dat_q[0] <= in_dat_i;
        for (int i = 1; i < Depth; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    assign out_vld_o = vld_q[Depth-1];
    assign out_dat_o = vld_q[Depth-1] ? dat_q[Depth-1] : '0;

endmodule

// File: rtl/data_mem_responder.sv
// OBI-style word memory responder: grant after GntStall cycles, response Latency cycles after grant.
// Grants are throttled to MaxOutstanding in flight; responses have no backpressure.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned GntStall       = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned IdxW   = idx_width(MemWords);
    localparam int unsigned OutW   = $clog2(MaxOutstanding + 1);
    localparam int unsigned StallW = cnt_width(GntStall);

    localparam logic [32:0] Base33  = {1'b0, BaseAddr};
    localparam logic [32:0] Limit33 = Base33 + (33'(MemWords) * 33'(WordBytes));

    logic [31:0]       mem_q [MemWords];
    logic [32:0]       addr33;
    logic [31:0]       offs;
    logic [IdxW-1:0]   word_idx;
    logic              in_range;

    logic [OutW-1:0]   out_q, out_d;
    logic [OutW-1:0]   slots_busy;
    logic [StallW-1:0] stall_q, stall_d;
    logic              gnt;

    mem_rsp_t          rsp_in;
    mem_rsp_t          rsp_out;
    logic              rsp_vld;

    assign addr33   = {1'b0, data_addr_i};
    assign in_range = (addr33 >= Base33) && (addr33 < Limit33);
    assign offs     = data_addr_i - BaseAddr;
    assign word_idx = IdxW'(offs >> 2);

    // A slot whose response leaves this cycle may be reused by a grant in the same cycle.
    assign slots_busy = out_q - OutW'(rsp_vld);
    assign gnt = data_req_i & ~rst_i & (stall_q == '0)
               & (slots_busy < OutW'(MaxOutstanding));

    always_comb begin
        stall_d = stall_q;
        if (gnt) begin
            stall_d = StallW'(GntStall);
        end else if (data_req_i && (stall_q != '0)) begin
            stall_d = stall_q - 1'b1;
        end
    end

    always_comb begin
        out_d = out_q;
        case ({gnt, rsp_vld})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q   <= '0;
            stall_q <= StallW'(GntStall);
        end else begin
            out_q   <= out_d;
            stall_q <= stall_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt && data_we_i && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (data_be_i[i]) begin
                    mem_q[word_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_in.rdata = (in_range && !data_we_i) ? mem_q[word_idx] : 32'h0;
        rsp_in.err   = ~in_range;
    end

    mem_rsp_pipe #(
        .Depth (Latency)
    ) u_rsp_pipe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_vld_i  (gnt),
        .in_dat_i  (rsp_in),
        .out_vld_o (rsp_vld),
        .out_dat_o (rsp_out)
    );

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rsp_vld;
    assign data_rdata_o  = rsp_out.rdata;
    assign data_err_o    = rsp_out.err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench over five responder configurations sharing one clock.
module tb_data_mem_responder;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       req, we, gnt, rvalid, err;
    logic [4:0][3:0]  be;
    logic [4:0][31:0] addr, wdata, rdata;

    int total = 0;
    int bad   = 0;
    int gcount, rcount;
    logic [11:0] gexp, rexp;
    logic [5:0]  g5;

    always #5 clk = ~clk;

    data_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(1), .MaxOutstanding(1), .GntStall(0)) u_a (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[0]), .data_gnt_o(gnt[0]), .data_we_i(we[0]),
        .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
        .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]));

    data_mem_responder #(.MemWords(16), .BaseAddr(32'h1000), .Latency(1), .MaxOutstanding(1), .GntStall(0)) u_b (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[1]), .data_gnt_o(gnt[1]), .data_we_i(we[1]),
        .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]));

    data_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(3), .MaxOutstanding(2), .GntStall(0)) u_c (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[2]), .data_gnt_o(gnt[2]), .data_we_i(we[2]),
        .data_be_i(be[2]), .data_addr_i(addr[2]), .data_wdata_i(wdata[2]),
        .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]));

    data_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(1), .MaxOutstanding(1), .GntStall(2)) u_d (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[3]), .data_gnt_o(gnt[3]), .data_we_i(we[3]),
        .data_be_i(be[3]), .data_addr_i(addr[3]), .data_wdata_i(wdata[3]),
        .data_rvalid_o(rvalid[3]), .data_rdata_o(rdata[3]), .data_err_o(err[3]));

    data_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(4), .MaxOutstanding(4), .GntStall(0)) u_e (
        .clk_i(clk), .rst_i(rst), .data_req_i(req[4]), .data_gnt_o(gnt[4]), .data_we_i(we[4]),
        .data_be_i(be[4]), .data_addr_i(addr[4]), .data_wdata_i(wdata[4]),
        .data_rvalid_o(rvalid[4]), .data_rdata_o(rdata[4]), .data_err_o(err[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int k, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
        req[k]   = 1'b1;
        we[k]    = w;
        be[k]    = b;
        addr[k]  = a;
        wdata[k] = d;
    endtask

    task automatic idle(input int k);
        req[k]   = 1'b0;
        we[k]    = 1'b0;
        be[k]    = 4'h0;
        addr[k]  = 32'h0;
        wdata[k] = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 5; k++) idle(k);

        // Reset state, with a request pending on instance A.
        #2;
        req[0] = 1'b1;
        #1;
        chk("rst_gnt",    32'(gnt[0]),    32'h0);
        chk("rst_rvalid", 32'(rvalid[0]), 32'h0);
        chk("rst_rdata",  rdata[0],       32'h0);
        chk("rst_err",    32'(err[0]),    32'h0);
        req[0] = 1'b0;
        adv();
        adv();
        rst = 1'b0;

        // Single write then read.
        adv(); drv(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        #1 chk("t1_wr_gnt", 32'(gnt[0]), 32'h1);
        adv();
        chk("t1_wr_rvalid", 32'(rvalid[0]), 32'h1);
        chk("t1_wr_rdata",  rdata[0],       32'h0);
        chk("t1_wr_err",    32'(err[0]),    32'h0);
        drv(0, 1'b0, 4'hF, 32'h10, 32'h0);
        #1 chk("t1_rd_gnt", 32'(gnt[0]), 32'h1);
        adv(); idle(0);
        chk("t1_rd_rvalid", 32'(rvalid[0]), 32'h1);
        chk("t1_rd_rdata",  rdata[0],       32'hDEADBEEF);
        chk("t1_rd_err",    32'(err[0]),    32'h0);
        adv();
        chk("t1_idle_rvalid", 32'(rvalid[0]), 32'h0);
        chk("t1_idle_rdata",  rdata[0],       32'h0);

        // Byte-enable merge.
        adv(); drv(0, 1'b1, 4'hF, 32'h20, 32'h11223344);
        #1 chk("t2_wr0_gnt", 32'(gnt[0]), 32'h1);
        adv(); drv(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
        #1 chk("t2_wr1_gnt", 32'(gnt[0]), 32'h1);
        adv(); drv(0, 1'b0, 4'h0, 32'h20, 32'h0);
        #1 chk("t2_rd_gnt", 32'(gnt[0]), 32'h1);
        adv(); idle(0);
        chk("t2_rd_rvalid", 32'(rvalid[0]), 32'h1);
        chk("t2_rd_rdata",  rdata[0],       32'h11BB33DD);

        // Out-of-range accesses on a 16-word window at 0x1000.
        adv(); drv(1, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D);
        adv(); chk("t3_wr_lo_err", 32'(err[1]), 32'h0);
        drv(1, 1'b1, 4'hF, 32'h103C, 32'h12345678);
        adv(); chk("t3_wr_hi_err", 32'(err[1]), 32'h0);
        drv(1, 1'b0, 4'hF, 32'h1040, 32'h0);
        adv();
        chk("t3_oor_rd_rvalid", 32'(rvalid[1]), 32'h1);
        chk("t3_oor_rd_err",    32'(err[1]),    32'h1);
        chk("t3_oor_rd_rdata",  rdata[1],       32'h0);
        drv(1, 1'b1, 4'hF, 32'h0FFC, 32'h55555555);
        #1 chk("t3_oor_wr_gnt", 32'(gnt[1]), 32'h1);
        adv();
        chk("t3_oor_wr_err",   32'(err[1]), 32'h1);
        chk("t3_oor_wr_rdata", rdata[1],    32'h0);
        drv(1, 1'b0, 4'hF, 32'h1000, 32'h0);
        adv();
        chk("t3_lo_rdata", rdata[1],    32'hCAFEF00D);
        chk("t3_lo_err",   32'(err[1]), 32'h0);
        drv(1, 1'b0, 4'hF, 32'h103C, 32'h0);
        adv(); idle(1);
        chk("t3_hi_rdata", rdata[1],    32'h12345678);
        chk("t3_hi_err",   32'(err[1]), 32'h0);

        // Throttling with Latency=3, MaxOutstanding=2: preload six words, then six held reads.
        gcount = 0;
        for (int c = 0; c < 40 && gcount < 6; c++) begin
            adv(); drv(2, 1'b1, 4'hF, 32'(gcount * 4), 32'hA0 + 32'(gcount));
            #1;
            if (gnt[2]) gcount++;
        end
        adv(); idle(2);
        chk("t4_preload_grants", 32'(gcount), 32'd6);
        repeat (4) adv();

        gexp = 12'b0000_1101_1011;
        rexp = 12'b0110_1101_1000;
        gcount = 0;
        rcount = 0;
        for (int c = 0; c < 12; c++) begin
            adv();
            chk($sformatf("t4_rvalid_c%0d", c), 32'(rvalid[2]), 32'(rexp[c]));
            if (rvalid[2]) begin
                chk($sformatf("t4_rdata_c%0d", c), rdata[2], 32'hA0 + 32'(rcount));
                rcount++;
            end
            if (gcount < 6) drv(2, 1'b0, 4'hF, 32'(gcount * 4), 32'h0);
            else idle(2);
            #1 chk($sformatf("t4_gnt_c%0d", c), 32'(gnt[2]), 32'(gexp[c]));
            if (gnt[2]) gcount++;
        end
        chk("t4_rsp_count", 32'(rcount), 32'd6);

        // Grant stall of two cycles before each grant.
        g5 = 6'b100100;
        for (int c = 0; c < 6; c++) begin
            adv();
            if (c < 3) drv(3, 1'b1, 4'hF, 32'h0, 32'h77);
            else       drv(3, 1'b0, 4'hF, 32'h0, 32'h0);
            #1 chk($sformatf("t5_gnt_c%0d", c), 32'(gnt[3]), 32'(g5[c]));
        end
        adv(); idle(3);
        chk("t5_rd_rvalid", 32'(rvalid[3]), 32'h1);
        chk("t5_rd_rdata",  rdata[3],       32'h77);

        // Reset while a read is in flight (Latency=4).
        adv(); drv(4, 1'b1, 4'hF, 32'h8, 32'h600D600D);
        #1 chk("t6_wr_gnt", 32'(gnt[4]), 32'h1);
        adv(); idle(4);
        repeat (3) adv();
        chk("t6_wr_rvalid", 32'(rvalid[4]), 32'h1);
        adv(); drv(4, 1'b0, 4'hF, 32'h8, 32'h0);
        #1 chk("t6_rd_gnt", 32'(gnt[4]), 32'h1);
        adv(); idle(4);
        adv(); rst = 1'b1; drv(4, 1'b0, 4'hF, 32'h8, 32'h0);
        #1 chk("t6_rst_gnt", 32'(gnt[4]), 32'h0);
        adv(); rst = 1'b0; idle(4);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) adv();
            chk($sformatf("t6_dropped_c%0d", c), 32'(rvalid[4]), 32'h0);
        end
        for (int c = 0; c < 4; c++) begin
            adv(); drv(4, 1'b0, 4'hF, 32'h8, 32'h0);
            #1 chk($sformatf("t6_post_gnt%0d", c), 32'(gnt[4]), 32'h1);
        end
        for (int c = 0; c < 4; c++) begin
            adv(); idle(4);
            chk($sformatf("t6_post_rvalid%0d", c), 32'(rvalid[4]), 32'h1);
            chk($sformatf("t6_post_rdata%0d", c),  rdata[4],       32'h600D600D);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
